// File: rtl/add_sum_merge.sv
// Merges the two round-robin add_sum lane result streams back into one in-order stream.
// Optional out_cnt transfer counter is enabled with `define ADD_SUM_MERGE_CNT_EN.
module add_sum_merge #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  flush,
    input  logic                  lane0_valid,
    input  logic [DATA_WIDTH-1:0] lane0_data,
    output logic                  lane0_ready,
    input  logic                  lane1_valid,
    input  logic [DATA_WIDTH-1:0] lane1_data,
    output logic                  lane1_ready,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_lane
`ifdef ADD_SUM_MERGE_CNT_EN
    ,
    output logic [31:0]           out_cnt
`endif
);

    localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW = AW + 1;

    logic [CW-1:0]         cnt_q  [2];
    logic [CW-1:0]         cnt_d  [2];
    logic [AW-1:0]         wptr_q [2];
    logic [AW-1:0]         wptr_d [2];
    logic [AW-1:0]         rptr_q [2];
    logic [AW-1:0]         rptr_d [2];
    logic                  sel_q;
    logic                  sel_d;
    logic [1:0]            lane_valid;
    logic [1:0]            lane_ready;
    logic [1:0]            push;
    logic [1:0]            pop_lane;
    logic                  pop;
    logic [DATA_WIDTH-1:0] wdata  [2];
    logic [DATA_WIDTH-1:0] mem    [2][FIFO_DEPTH];

    assign lane_valid = {lane1_valid, lane0_valid};
    assign wdata[0]   = lane0_data;
    assign wdata[1]   = lane1_data;

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            lane_ready[i] = (cnt_q[i] != CW'(FIFO_DEPTH));
            push[i]       = lane_valid[i] & lane_ready[i];
        end
        out_valid = (cnt_q[sel_q] != '0);
        pop       = out_valid & out_ready;
        for (int i = 0; i < 2; i++) begin
            pop_lane[i] = pop & (sel_q == 1'(i));
        end
    end

    assign lane0_ready = lane_ready[0];
    assign lane1_ready = lane_ready[1];
    assign out_data    = mem[sel_q][rptr_q[sel_q]];
    assign out_lane    = sel_q;

    // Flush wins over any transfer in the same cycle; the transfer is simply dropped.
    always_comb begin
        sel_d = sel_q;
        for (int i = 0; i < 2; i++) begin
            cnt_d[i]  = cnt_q[i];
            wptr_d[i] = wptr_q[i];
            rptr_d[i] = rptr_q[i];
        end
        if (flush) begin
            sel_d = 1'b0;
            for (int i = 0; i < 2; i++) begin
                cnt_d[i]  = '0;
                wptr_d[i] = '0;
                rptr_d[i] = '0;
            end
        end else begin
            if (pop) begin
                sel_d = ~sel_q;
            end
            for (int i = 0; i < 2; i++) begin
                cnt_d[i] = cnt_q[i] + CW'(push[i]) - CW'(pop_lane[i]);
                if (push[i]) begin
                    wptr_d[i] = wptr_q[i] + AW'(1);
                end
                if (pop_lane[i]) begin
                    rptr_d[i] = rptr_q[i] + AW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sel_q <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                cnt_q[i]  <= '0;
                wptr_q[i] <= '0;
                rptr_q[i] <= '0;
            end
        end else begin
            sel_q <= sel_d;
            for (int i = 0; i < 2; i++) begin
                cnt_q[i]  <= cnt_d[i];
                wptr_q[i] <= wptr_d[i];
                rptr_q[i] <= rptr_d[i];
            end
        end
    end

    // Storage carries no reset; entries are only visible through valid counts.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (push[i] && !flush) begin
                mem[i][wptr_q[i]] <= wdata[i];
            end
        end
    end

`ifdef ADD_SUM_MERGE_CNT_EN
    logic [31:0] out_cnt_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            out_cnt_q <= '0;
        end else if (flush) begin
            out_cnt_q <= '0;
        end else if (pop) begin
            out_cnt_q <= out_cnt_q + 32'd1;
        end
    end

    assign out_cnt = out_cnt_q;
`endif

endmodule

// File: tb/tb_add_sum_merge.sv
// Self-checking bench for add_sum_merge: directed scenarios plus random traffic against
// a queue-based reference model of the two lane FIFOs and the alternating merge.
module tb_add_sum_merge;

    localparam int unsigned DW    = 32;
    localparam int unsigned DEPTH = 4;

    logic          clk = 1'b0;
    logic          rstn;
    logic          flush;
    logic          lane0_valid;
    logic [DW-1:0] lane0_data;
    logic          lane0_ready;
    logic          lane1_valid;
    logic [DW-1:0] lane1_data;
    logic          lane1_ready;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic          out_lane;
`ifdef ADD_SUM_MERGE_CNT_EN
    logic [31:0]   out_cnt;
`endif

    add_sum_merge #(
        .DATA_WIDTH(DW),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .flush      (flush),
        .lane0_valid(lane0_valid),
        .lane0_data (lane0_data),
        .lane0_ready(lane0_ready),
        .lane1_valid(lane1_valid),
        .lane1_data (lane1_data),
        .lane1_ready(lane1_ready),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_lane   (out_lane)
`ifdef ADD_SUM_MERGE_CNT_EN
        ,
        .out_cnt    (out_cnt)
`endif
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] q0[$];
    logic [31:0] q1[$];
    logic        m_sel;
    logic [31:0] m_cnt;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit model_valid();
        return m_sel ? (q1.size() != 0) : (q0.size() != 0);
    endfunction

    task automatic model_clear();
        q0.delete();
        q1.delete();
        m_sel = 1'b0;
        m_cnt = '0;
    endtask

    task automatic check_outputs();
        check_eq("out_valid", 32'(out_valid), 32'(model_valid()));
        check_eq("lane0_ready", 32'(lane0_ready), 32'(q0.size() < DEPTH));
        check_eq("lane1_ready", 32'(lane1_ready), 32'(q1.size() < DEPTH));
        check_eq("out_lane", 32'(out_lane), 32'(m_sel));
        if (model_valid()) begin
            check_eq("out_data", out_data, m_sel ? q1[0] : q0[0]);
        end
`ifdef ADD_SUM_MERGE_CNT_EN
        check_eq("out_cnt", out_cnt, m_cnt);
`endif
    endtask

    // Called just after a falling edge: check, drive, take one rising edge, update model.
    task automatic step(input bit v0, input logic [31:0] d0, input bit v1,
                        input logic [31:0] d1, input bit rdy, input bit fl);
        bit p0, p1, pop;
        check_outputs();
        lane0_valid = v0;
        lane0_data  = d0;
        lane1_valid = v1;
        lane1_data  = d1;
        out_ready   = rdy;
        flush       = fl;
        p0  = v0 && (q0.size() < DEPTH);
        p1  = v1 && (q1.size() < DEPTH);
        pop = rdy && model_valid();
        @(posedge clk);
        if (fl) begin
            model_clear();
        end else begin
            if (pop) begin
                if (m_sel) void'(q1.pop_front());
                else       void'(q0.pop_front());
                m_sel = ~m_sel;
                m_cnt = m_cnt + 32'd1;
            end
            if (p0) q0.push_back(d0);
            if (p1) q1.push_back(d1);
        end
        @(negedge clk);
    endtask

    task automatic idle(input bit rdy);
        step(1'b0, '0, 1'b0, '0, rdy, 1'b0);
    endtask

    task automatic out_of_order();
        idle(1'b1);
        step(1'b0, '0, 1'b1, 32'hB1, 1'b1, 1'b0);
        check_eq("ooo_nothing_early", 32'(out_valid), 32'd0);
        idle(1'b1);
        step(1'b1, 32'hA0, 1'b0, '0, 1'b1, 1'b0);
        check_eq("ooo_first_data", out_data, 32'hA0);
        check_eq("ooo_first_lane", 32'(out_lane), 32'd0);
        idle(1'b1);
        check_eq("ooo_second_data", out_data, 32'hB1);
        check_eq("ooo_second_lane", 32'(out_lane), 32'd1);
        idle(1'b1);
        check_eq("ooo_drained", 32'(out_valid), 32'd0);
    endtask

    initial begin
        rstn        = 1'b0;
        flush       = 1'b0;
        lane0_valid = 1'b0;
        lane0_data  = '0;
        lane1_valid = 1'b0;
        lane1_data  = '0;
        out_ready   = 1'b0;
        model_clear();
        #1;
        check_outputs();
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b1;

        out_of_order();

        // Streaming, both lanes every cycle.
        for (int k = 0; k < 3; k++) begin
            step(1'b1, 32'h10 + 32'(2 * k), 1'b1, 32'h11 + 32'(2 * k), 1'b1, 1'b0);
        end
        repeat (7) idle(1'b1);

        // Backpressure on lane 0; the fifth value is held by the source until accepted.
        for (int k = 0; k < 5; k++) begin
            step(1'b1, 32'h20 + 32'(k), 1'b0, '0, 1'b0, 1'b0);
        end
        check_eq("bp_lane0_full", 32'(lane0_ready), 32'd0);
        step(1'b1, 32'h24, 1'b1, 32'h30, 1'b1, 1'b0);
        check_eq("bp_ready_back", 32'(lane0_ready), 32'd1);
        for (int k = 1; k < 6; k++) begin
            step(k == 1, 32'h24, 1'b1, 32'h30 + 32'(k), 1'b1, 1'b0);
        end
        step(1'b0, '0, 1'b0, '0, 1'b0, 1'b1);

        // Flush with lane0 holding two entries, lane1 one, sel = 1.
        step(1'b1, 32'h41, 1'b1, 32'h42, 1'b0, 1'b0);
        step(1'b1, 32'h43, 1'b0, '0, 1'b0, 1'b0);
        step(1'b1, 32'h44, 1'b0, '0, 1'b1, 1'b0);
        check_eq("pre_flush_sel", 32'(out_lane), 32'd1);
        step(1'b1, 32'h99, 1'b0, '0, 1'b1, 1'b1);
        check_eq("flush_out_valid", 32'(out_valid), 32'd0);
        check_eq("flush_sel", 32'(out_lane), 32'd0);
        step(1'b1, 32'h55, 1'b0, '0, 1'b0, 1'b0);
        check_eq("post_flush_data", out_data, 32'h55);
        check_eq("post_flush_valid", 32'(out_valid), 32'd1);
        idle(1'b1);

        // Random traffic against the model.
        for (int k = 0; k < 400; k++) begin
            step(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)), $urandom,
                 $urandom_range(0, 3) != 0, $urandom_range(0, 39) == 0);
        end

        // Asynchronous reset with three entries buffered.
        step(1'b0, '0, 1'b0, '0, 1'b0, 1'b1);
        step(1'b1, 32'h61, 1'b1, 32'h62, 1'b0, 1'b0);
        step(1'b1, 32'h63, 1'b0, '0, 1'b0, 1'b0);
        check_eq("pre_reset_valid", 32'(out_valid), 32'd1);
        lane0_valid = 1'b0;
        lane1_valid = 1'b0;
        #2 rstn = 1'b0;
        #1;
        check_eq("async_rst_valid", 32'(out_valid), 32'd0);
        check_eq("async_rst_rdy0", 32'(lane0_ready), 32'd1);
        check_eq("async_rst_rdy1", 32'(lane1_ready), 32'd1);
        model_clear();
        @(negedge clk);
        rstn = 1'b1;
        out_of_order();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/add_sum_merge.md
Name: add_sum_merge

Overview:
- Collector stage that pairs with the round-robin two-lane add_sum dispatcher.
- The dispatcher sends consecutive inputs alternately to lane 0 and lane 1, starting with lane 0.
- This block takes the two per-lane result streams, buffers each in a small FIFO, and recombines them into one in-order output stream with valid/ready handshake.
- It sits between the two add_sum lanes and the downstream SpMV result writer.

Parameters:
- DATA_WIDTH, 32, width of one lane result and of out_data.
- FIFO_DEPTH, 4, entries per lane FIFO; power of two, minimum 2.

Ports:
- clk  input  1  clock.
- rstn  input  1  reset, asynchronous, active-low.
- flush  input  1  synchronous clear of FIFOs and lane pointer.
- lane0_valid  input  1  lane 0 result valid.
- lane0_data  input  DATA_WIDTH  lane 0 result.
- lane0_ready  output  1  lane 0 FIFO can accept.
- lane1_valid  input  1  lane 1 result valid.
- lane1_data  input  DATA_WIDTH  lane 1 result.
- lane1_ready  output  1  lane 1 FIFO can accept.
- out_valid  output  1  merged result valid.
- out_ready  input  1  downstream accepts.
- out_data  output  DATA_WIDTH  merged result.
- out_lane  output  1  lane that out_data came from (equals sel).

Behaviour:
- Reset (rstn low, async):
  - both FIFO counts, read pointers and write pointers = 0; sel = 0.
  - out_valid = 0, lane0_ready = lane1_ready = 1, out_lane = 0.
  - FIFO storage is not reset; out_data is don't-care while out_valid = 0.
- Per lane i:
  - FIFO of FIFO_DEPTH entries; count width clog2(FIFO_DEPTH)+1.
  - laneI_ready = (count_i != FIFO_DEPTH), derived from registered count.
  - Push when laneI_valid & laneI_ready. Write pointer wraps modulo FIFO_DEPTH.
  - No push when full, even if a pop happens the same cycle (no pass-through on full).
- Merge:
  - 1-bit register sel selects the lane expected next.
  - out_valid = (count_sel != 0); out_data = head entry of FIFO[sel]; both driven combinationally from registers.
  - Pop when out_valid & out_ready: read pointer of FIFO[sel] advances (wraps), count decrements, and sel toggles.
  - If FIFO[sel] is empty, output stalls even when the other FIFO holds data. Strict alternation 0,1,0,1,… preserves original input order.
- Latency:
  - A push into an empty FIFO[sel] at edge N gives out_valid = 1 after edge N (one cycle).
  - Output throughput is one result per cycle when both lanes keep data available.
- Push and pop on the same FIFO in one cycle: count unchanged, both pointers advance. Valid at any non-full count, including count = 1.
- Simultaneous pushes to both lanes in one cycle are allowed and independent.
- out_valid stays asserted and out_data stays stable until accepted (AXI-stream rule).
- flush = 1:
  - at the next edge, counts and pointers go to 0 and sel goes to 0.
  - overrides any push or pop in the same cycle; the transfer is dropped.
  - laneX_ready and out_valid still show pre-flush values during the flush cycle.
- Reset mid-operation: all buffered results are discarded immediately and the block comes up in the reset state.

Optional Feature:
- Macro ADD_SUM_MERGE_CNT_EN.
- Defined:
  - extra output out_cnt [31:0], reset 0.
  - increments by 1 on every out_valid & out_ready; wraps at 2^32.
  - cleared by flush, and flush takes priority.
- Undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset then idle -> out_valid=0, lane0_ready=lane1_ready=1, out_lane=0 (out_cnt=0 if enabled).
- Out-of-order arrival: push lane1=0xB1 at cycle 1, lane0=0xA0 at cycle 3, out_ready=1 -> out_data=0xA0 (out_lane=0) in cycle 4, then 0xB1 (out_lane=1) in cycle 5; nothing output before cycle 4.
- Streaming with out_ready=1: lane0 pushes 0x10,0x12,0x14 and lane1 pushes 0x11,0x13,0x15, both lanes every cycle -> output sequence 0x10..0x15, one per cycle after the first.
- Backpressure, FIFO_DEPTH=4, out_ready=0: push 5 values on lane0 -> lane0_ready=0 after the 4th; the 5th is held by the source. Raise out_ready with lane1 supplying data -> lane0 entries drain in order and lane0_ready returns to 1 one cycle after the first lane0 pop.
- Flush with lane0 holding 2 entries and lane1 holding 1, sel=1 -> next cycle: counts 0, out_valid=0, sel=0. A subsequent lane0 push of 0x55 outputs 0x55 on out_lane=0.
- Async reset asserted mid-stream (3 entries buffered) -> out_valid drops without waiting for a clock edge; after release, behaviour matches the first scenario.
